// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC, issues one memory request at a
// time, holds the fetched word for decode, and handles redirects, memory
// timeouts and misaligned redirect targets.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
  parameter int unsigned MAX_WAIT     = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        timeout,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERROR} state_e;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        flush_q, flush_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] inst_out_q, inst_out_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        timeout_q, timeout_d;
  logic        misalign_q, misalign_d;

  logic redir_ok, redir_bad;
  assign redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
  assign redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);

  // Next-state, PC and capture logic; everything holds unless a rule fires.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    flush_d    = flush_q;
    wait_d     = wait_q;
    inst_out_d = inst_out_q;
    inst_pc_d  = inst_pc_q;
    timeout_d  = timeout_q;
    misalign_d = misalign_q;
    case (state_q)
      S_IDLE: begin
        wait_d = 8'd0;
        if (redir_bad) begin
          state_d    = S_ERROR;
          misalign_d = 1'b1;
        end else if (redir_ok) begin
          pc_d    = redirect_target;
          state_d = halt ? S_IDLE : S_REQ;
        end else if (!halt) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redir_bad) begin
          state_d    = S_ERROR;
          misalign_d = 1'b1;
          wait_d     = 8'd0;
          flush_d    = 1'b0;
        end else if (imem_ack) begin
          wait_d = 8'd0;
          if (flush_q || redir_ok) begin
            // Returned word belongs to a stale path: drop it and refetch.
            pc_d    = redir_ok ? redirect_target : pend_q;
            flush_d = 1'b0;
          end else begin
            inst_out_d = imem_rdata;
            inst_pc_d  = pc_q;
            state_d    = S_HOLD;
          end
        end else begin
          // Request address stays put; a redirect is parked until the ack.
          if (redir_ok) begin
            pend_d  = redirect_target;
            flush_d = 1'b1;
          end
          if (wait_q == WAIT_LAST) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
            wait_d    = 8'd0;
            flush_d   = 1'b0;
          end else begin
            wait_d = wait_q + 8'd1;
          end
        end
      end
      S_HOLD: begin
        if (redir_bad) begin
          state_d    = S_ERROR;
          misalign_d = 1'b1;
        end else if (redir_ok) begin
          // Redirect wins over a same-cycle accept; no sequential advance.
          pc_d    = redirect_target;
          state_d = halt ? S_IDLE : S_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + 32'd4;
          state_d = halt ? S_IDLE : S_REQ;
        end
      end
      default: ; // S_ERROR: sticky until reset
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      pend_q     <= 32'd0;
      flush_q    <= 1'b0;
      wait_q     <= 8'd0;
      inst_out_q <= 32'd0;
      inst_pc_q  <= 32'd0;
      timeout_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      flush_q    <= flush_d;
      wait_q     <= wait_d;
      inst_out_q <= inst_out_d;
      inst_pc_q  <= inst_pc_d;
      timeout_q  <= timeout_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign inst_valid   = (state_q == S_HOLD);
  assign imem_addr    = pc_q;
  assign inst_out     = inst_out_q;
  assign inst_pc      = inst_pc_q;
  assign timeout      = timeout_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run scored
// against an instruction-stream model (expected PC of the next accepted word).
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        timeout;
  logic        misalign_err;

  fetch_sequencer #(.RESET_VECTOR(32'h0000_1000), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc),
    .timeout(timeout), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic sb_en = 1'b0;
  logic mem_auto = 1'b0;
  int lat = 0;
  int age = 0;
  int n_acc = 0;
  logic [31:0] exp_pc;
  logic [31:0] acked_q[$];
  logic [31:0] acc_pc_q[$];
  logic [31:0] hold_pc, hold_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: score the cycle's handshakes, clock, then run the memory model.
  task automatic tick();
    logic p_req, p_ack;
    logic [31:0] p_addr;
    if (sb_en) begin
      if (inst_valid && inst_ready && !redirect_valid) begin
        chk("sb_pc", inst_pc, exp_pc);
        chk("sb_inst", inst_out, mem_word(inst_pc));
        exp_pc += 32'd4;
        n_acc++;
      end
      if (redirect_valid) exp_pc = redirect_target;
    end
    if (imem_req && imem_ack) acked_q.push_back(imem_addr);
    if (inst_valid && inst_ready && !redirect_valid) acc_pc_q.push_back(inst_pc);
    p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
    @(posedge clk); #1;
    if (sb_en) begin
      chk("req_and_valid", 32'(imem_req && inst_valid), 32'd0);
      if (p_req && !p_ack && imem_req) chk("addr_hold", imem_addr, p_addr);
    end
    if (imem_req && p_req && !p_ack) age++; else age = 0;
    if (mem_auto) begin
      imem_ack   = imem_req && (age >= lat);
      imem_rdata = mem_word(imem_addr);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; imem_ack = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_1000);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    age = 0; n_acc = 0; exp_pc = 32'h0000_1000;
    acked_q.delete(); acc_pc_q.delete();
    chk("rel_no_req", 32'(imem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    imem_ack = 1'b0; imem_rdata = 32'd0; inst_ready = 1'b0;
    #2;

    // Sequential fetch, single-cycle acks, decode always ready.
    do_reset();
    sb_en = 1'b1; mem_auto = 1'b1; lat = 0; inst_ready = 1'b1;
    tick();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0000_1000);
    for (int i = 0; i < 30 && acc_pc_q.size() < 3; i++) tick();
    chk("seq_count", 32'(acc_pc_q.size() >= 3), 32'd1);
    if (acked_q.size() >= 3 && acc_pc_q.size() >= 3) begin
      chk("seq_addr0", acked_q[0], 32'h1000);
      chk("seq_addr1", acked_q[1], 32'h1004);
      chk("seq_addr2", acked_q[2], 32'h1008);
      chk("seq_pc2", acc_pc_q[2], 32'h1008);
    end

    // Decode back-pressure in HOLD.
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    chk("bp_valid", 32'(inst_valid), 32'd1);
    hold_pc = inst_pc; hold_inst = inst_out;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stay_valid", 32'(inst_valid), 32'd1);
      chk("bp_pc_stable", inst_pc, hold_pc);
      chk("bp_inst_stable", inst_out, hold_inst);
      chk("bp_no_req", 32'(imem_req), 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    chk("bp_next_req", 32'(imem_req), 32'd1);
    chk("bp_next_addr", imem_addr, hold_pc + 32'd4);

    // Redirect in HOLD beats a simultaneous accept.
    inst_ready = 1'b0;
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_3000; inst_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("hold_redir_valid", 32'(inst_valid), 32'd0);
    chk("hold_redir_addr", imem_addr, 32'h0000_3000);

    // Redirect during an outstanding request, ack two cycles later.
    do_reset();
    mem_auto = 1'b1; lat = 0; inst_ready = 1'b1;
    for (int i = 0; i < 20 && !(imem_req && imem_addr == 32'h1004); i++) tick();
    mem_auto = 1'b0; imem_ack = 1'b0;
    chk("fl_at_1004", imem_addr, 32'h1004);
    redirect_valid = 1'b1; redirect_target = 32'h0000_2000;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("fl_addr_held", imem_addr, 32'h1004);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    chk("fl_no_valid", 32'(inst_valid), 32'd0);
    chk("fl_reissue", 32'(imem_req), 32'd1);
    chk("fl_new_addr", imem_addr, 32'h0000_2000);

    // Ack and redirect together, then PC wrap from the top of memory.
    imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    mem_auto = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'hFFFF_FFFC);
    tick();
    chk("wrap_hold_pc", inst_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_req", 32'(imem_req), 32'd1);
    chk("wrap_zero", imem_addr, 32'h0000_0000);

    // Misaligned redirect is fatal until reset.
    mem_auto = 1'b0; imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0000_2002;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("mis_flag", 32'(misalign_err), 32'd1);
      chk("mis_no_req", 32'(imem_req), 32'd0);
      chk("mis_no_valid", 32'(inst_valid), 32'd0);
      imem_ack = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_4000;
      tick();
      imem_ack = 1'b0; redirect_valid = 1'b0;
    end

    // Memory never answers: timeout after MAX_WAIT request cycles.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_req", 32'(imem_req), 32'd1);
      chk("to_not_yet", 32'(timeout), 32'd0);
    end
    tick();
    chk("to_flag", 32'(timeout), 32'd1);
    chk("to_req_off", 32'(imem_req), 32'd0);
    do_reset();
    tick();
    chk("to_refetch_req", 32'(imem_req), 32'd1);
    chk("to_refetch_addr", imem_addr, 32'h0000_1000);

    // Randomized traffic against the stream model.
    do_reset();
    sb_en = 1'b1; mem_auto = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      lat             = int'($urandom_range(0, 2));
      halt            = ($urandom % 5) == 0;
      inst_ready      = ($urandom % 3) != 0;
      redirect_valid  = ($urandom % 20) == 0;
      redirect_target = $urandom & 32'hFFFF_FFFC;
      tick();
    end
    redirect_valid = 1'b0;
    chk("rand_progress", 32'(n_acc >= 100), 32'd1);
    chk("rand_no_timeout", 32'(timeout), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
